peripheral_7seg: RTL



---
 rtl/peripheral_7seg_pkg.sv | 51 +++++
 rtl/peripheral_7seg_decode.sv | 33 +++
 rtl/peripheral_7seg.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/peripheral_7seg_pkg.sv
// Shared constants for the 4-digit multiplexed seven-segment display peripheral:
// register offsets, CTRL bit positions, glyph codes and elaboration helpers.
package peripheral_7seg_pkg;

  localparam logic [4:0] OFF_DIGITS = 5'h00;
  localparam logic [4:0] OFF_DPM    = 5'h04;
  localparam logic [4:0] OFF_CTRL   = 5'h08;
  localparam logic [4:0] OFF_STATUS = 5'h0C;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_LZB   = 1;
  localparam int CTRL_MINUS = 2;
  localparam int CTRL_W     = 3;

  typedef struct packed {
    logic minus;
    logic lzb;
    logic en;
  } ctrl_t;

  // Segment order is {g,f,e,d,c,b,a}, active-high before board polarity is applied.
  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h7C;
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_D     = 7'h5E;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_F     = 7'h71;
  localparam logic [6:0] GLYPH_MINUS = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  function automatic int calc_div(input int clk_freq, input int scan_hz);
    int q;
    q = clk_freq / (scan_hz * 4);
    return (q < 2) ? 2 : q;
  endfunction

  function automatic int width_for(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/peripheral_7seg_decode.sv
// Combinational hex-nibble to seven-segment glyph ROM.
module seg7_decode
  import peripheral_7seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] glyph_o
);

  // Glyph lookup for the currently scanned nibble.
  always_comb begin
    glyph_o = GLYPH_BLANK;
    case (nibble_i)
      4'h0:    glyph_o = GLYPH_0;
      4'h1:    glyph_o = GLYPH_1;
      4'h2:    glyph_o = GLYPH_2;
      4'h3:    glyph_o = GLYPH_3;
      4'h4:    glyph_o = GLYPH_4;
      4'h5:    glyph_o = GLYPH_5;
      4'h6:    glyph_o = GLYPH_6;
      4'h7:    glyph_o = GLYPH_7;
      4'h8:    glyph_o = GLYPH_8;
      4'h9:    glyph_o = GLYPH_9;
      4'hA:    glyph_o = GLYPH_A;
      4'hB:    glyph_o = GLYPH_B;
      4'hC:    glyph_o = GLYPH_C;
      4'hD:    glyph_o = GLYPH_D;
      4'hE:    glyph_o = GLYPH_E;
      4'hF:    glyph_o = GLYPH_F;
      default: glyph_o = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/peripheral_7seg.sv
// Memory-mapped 4-digit multiplexed seven-segment driver: bus registers, scan
// prescaler with inter-digit dead time, leading-zero blanking and registered pins.
module peripheral_7seg
  import peripheral_7seg_pkg::*;
#(
  parameter int CLK_FREQ   = 26000000,
  parameter int SCAN_HZ    = 1000,
  parameter int DEAD_CYC   = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int DIV = calc_div(CLK_FREQ, SCAN_HZ);
  localparam int PW  = width_for(DIV - 1);
  localparam int DW  = width_for(DEAD_CYC);

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [DW-1:0] DEAD_LOAD  = DW'(DEAD_CYC);
  localparam logic [DW-1:0] DEAD_ONE   = DW'(1);

  localparam logic       POL_LOW = (ACTIVE_LOW != 0);
  localparam logic [6:0] SEG_OFF = {7{POL_LOW}};
  localparam logic [3:0] AN_OFF  = {4{POL_LOW}};
  localparam logic       DP_OFF  = POL_LOW;

  logic [15:0]   digits_q, digits_d;
  logic [3:0]    dpm_q, dpm_d;
  ctrl_t         ctrl_q, ctrl_d;
  logic [1:0]    idx_q, idx_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] dead_q, dead_d;
  logic          frame_done_q, frame_done_d;
  logic [31:0]   d_out_q, d_out_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;

  logic        wr_en_s, rd_en_s, status_rd_s;
  logic        wrap_s, frame_wrap_s;
  logic [31:0] rdata_s;
  logic [3:0]  nibble_s;
  logic [6:0]  glyph_s, seg_raw_s;
  logic [3:0]  an_raw_s;
  logic        dp_raw_s;
  logic        z1_s, z2_s, z3_s;
  logic        blank1_s, blank2_s, blank3_s, blank_sel_s;

  assign wr_en_s     = cs & wr;
  assign rd_en_s     = cs & rd;
  assign status_rd_s = rd_en_s & (addr == OFF_STATUS);

  // Register writes and read-data selection.
  always_comb begin
    digits_d = digits_q;
    dpm_d    = dpm_q;
    ctrl_d   = ctrl_q;
    if (wr_en_s) begin
      case (addr)
        OFF_DIGITS: digits_d = d_in;
        OFF_DPM:    dpm_d    = d_in[3:0];
        OFF_CTRL:   ctrl_d   = ctrl_t'(d_in[CTRL_W-1:0]);
        default:    digits_d = digits_q;
      endcase
    end else begin
      digits_d = digits_q;
    end

    case (addr)
      OFF_DIGITS: rdata_s = {16'h0000, digits_q};
      OFF_DPM:    rdata_s = {28'h0000000, dpm_q};
      OFF_CTRL:   rdata_s = {29'h00000000, ctrl_q};
      OFF_STATUS: rdata_s = {29'h00000000, frame_done_q, idx_q};
      default:    rdata_s = 32'h0000_0000;
    endcase
    d_out_d = rd_en_s ? rdata_s : d_out_q;
  end

  // Scan sequencing: prescaler, digit index, dead time and frame-done flag.
  always_comb begin
    wrap_s       = ctrl_q.en & (presc_q == PRESC_LAST);
    frame_wrap_s = wrap_s & (idx_q == 2'd3);
    if (!ctrl_q.en) begin
      presc_d = '0;
      idx_d   = 2'd0;
      dead_d  = '0;
    end else if (wrap_s) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
      dead_d  = DEAD_LOAD;
    end else begin
      presc_d = presc_q + PRESC_ONE;
      idx_d   = idx_q;
      dead_d  = (dead_q != '0) ? (dead_q - DEAD_ONE) : dead_q;
    end

    // A wrap on the same edge as a STATUS read keeps the flag set.
    if (frame_wrap_s) begin
      frame_done_d = 1'b1;
    end else if (status_rd_s) begin
      frame_done_d = 1'b0;
    end else begin
      frame_done_d = frame_done_q;
    end
  end

  assign nibble_s = digits_q[{idx_q, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble_i (nibble_s),
    .glyph_o  (glyph_s)
  );

  // Blanking chain runs from the top significant digit downwards.
  always_comb begin
    z3_s     = (digits_q[15:12] == 4'h0);
    z2_s     = (digits_q[11:8]  == 4'h0);
    z1_s     = (digits_q[7:4]   == 4'h0);
    blank3_s = ctrl_q.lzb & z3_s & ~ctrl_q.minus;
    blank2_s = ctrl_q.lzb & z2_s & (ctrl_q.minus | z3_s);
    blank1_s = blank2_s & z1_s;
    case (idx_q)
      2'd1:    blank_sel_s = blank1_s;
      2'd2:    blank_sel_s = blank2_s;
      2'd3:    blank_sel_s = blank3_s;
      default: blank_sel_s = 1'b0;
    endcase

    if (!ctrl_q.en) begin
      seg_raw_s = GLYPH_BLANK;
      dp_raw_s  = 1'b0;
      an_raw_s  = 4'h0;
    end else begin
      if (ctrl_q.minus && (idx_q == 2'd3)) begin
        seg_raw_s = GLYPH_MINUS;
      end else if (blank_sel_s) begin
        seg_raw_s = GLYPH_BLANK;
      end else begin
        seg_raw_s = glyph_s;
      end
      dp_raw_s = dpm_q[idx_q];
      an_raw_s = (dead_q == '0) ? (4'b0001 << idx_q) : 4'h0;
    end

    seg_d = seg_raw_s ^ SEG_OFF;
    dp_d  = dp_raw_s ^ DP_OFF;
    an_d  = an_raw_s ^ AN_OFF;
  end

  // State and output registers; reset drives the pins to their inactive level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits_q     <= 16'h0000;
      dpm_q        <= 4'h0;
      ctrl_q       <= '0;
      idx_q        <= 2'd0;
      presc_q      <= '0;
      dead_q       <= '0;
      frame_done_q <= 1'b0;
      d_out_q      <= 32'h0000_0000;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
    end else begin
      digits_q     <= digits_d;
      dpm_q        <= dpm_d;
      ctrl_q       <= ctrl_d;
      idx_q        <= idx_d;
      presc_q      <= presc_d;
      dead_q       <= dead_d;
      frame_done_q <= frame_done_d;
      d_out_q      <= d_out_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign d_out = d_out_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign an    = an_q;

endmodule
